// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle sequencer that sits between the CTI-8 control unit and the
// 8-bit combinational ALU. It accepts one operation per valid/ready handshake
// and feeds the ALU one byte per cycle. Carry is chained between bytes for
// 16-bit operations. ROL1/ROR1 are repeated (reqCount+1) times through carry.
// The result and flags are held until the consumer takes them.
//
// Ports
//   clk, reset               : single clock, synchronous active-high reset
//   reqValid/reqReady        : request handshake (reqReady high only in IDLE)
//   reqOp, reqWide, reqCount : opcode, 16-bit select, rotate repeat count
//   reqA, reqB               : 16-bit operands (narrow ops use [7:0])
//   reqCarry, reqHalf        : initial carry-in, half-carry for DAAP/DAAS
//   aluA, aluB, aluCarryIn,
//   aluHalfCarry, aluOpcode,
//   aluOutputEnable          : drive to the ALU (all zero when not stepping)
//   aluResult, aluC/V/H      : combinational ALU outputs
//   rspValid/rspReady        : response handshake
//   rspResult, rspC/V/H/Z/N  : held result and flags (zero outside RESP)
// -----------------------------------------------------------------------------
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [3:0]  reqOp,
    input  logic        reqWide,
    input  logic [2:0]  reqCount,
    input  logic [15:0] reqA,
    input  logic [15:0] reqB,
    input  logic        reqCarry,
    input  logic        reqHalf,
    output logic [7:0]  aluA,
    output logic [7:0]  aluB,
    output logic        aluCarryIn,
    output logic        aluHalfCarry,
    output logic [3:0]  aluOpcode,
    output logic        aluOutputEnable,
    input  logic [7:0]  aluResult,
    input  logic        aluC,
    input  logic        aluV,
    input  logic        aluH,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [15:0] rspResult,
    output logic        rspC,
    output logic        rspV,
    output logic        rspH,
    output logic        rspZ,
    output logic        rspN
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BYTE0 = 2'd1,
        ST_BYTE1 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ROL1 = 4'd5;
    localparam logic [3:0] OP_ROR1 = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'hB;

    // Only ADD..ROR1 and NOT have a 16-bit form.
    function automatic logic wide_honoured(input logic [3:0] op);
        return (op <= OP_ROR1) || (op == OP_NOT);
    endfunction

    function automatic logic is_rotate(input logic [3:0] op);
        return (op == OP_ROL1) || (op == OP_ROR1);
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] work_a_r;
    logic [15:0] work_b_r;
    logic        carry_r;
    logic        half_r;
    logic [3:0]  op_r;
    logic        wide_r;
    logic [2:0]  remaining_r;
    logic        vflag_r;
    logic        hflag_r;

    logic        step_s;      // an ALU byte step is executing this cycle
    logic        hi_sel_s;    // the step works on the high byte
    logic        iter_end_s;  // this step closes one pass over the operand
    logic        ror_wide_s;

    // Wide ROR1 must shift the high byte first so its bit 0 carries into the low byte.
    assign ror_wide_s = wide_r && (op_r == OP_ROR1);

    assign reqReady = (state_r == ST_IDLE);
    assign rspValid = (state_r == ST_RESP);

    // Decode which byte the current step handles and whether the pass ends here.
    always_comb begin
        step_s     = 1'b0;
        hi_sel_s   = 1'b0;
        iter_end_s = 1'b0;
        case (state_r)
            ST_BYTE0: begin
                step_s     = 1'b1;
                hi_sel_s   = ror_wide_s;
                iter_end_s = !wide_r;
            end
            ST_BYTE1: begin
                step_s     = 1'b1;
                hi_sel_s   = !ror_wide_s;
                iter_end_s = 1'b1;
            end
            default: begin
                step_s     = 1'b0;
                hi_sel_s   = 1'b0;
                iter_end_s = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (reqValid) state_next_s = ST_BYTE0;
                else          state_next_s = ST_IDLE;
            end
            ST_BYTE0: begin
                if (wide_r)                    state_next_s = ST_BYTE1;
                else if (remaining_r != 3'd0)  state_next_s = ST_BYTE0;
                else                           state_next_s = ST_RESP;
            end
            ST_BYTE1: begin
                if (remaining_r != 3'd0) state_next_s = ST_BYTE0;
                else                     state_next_s = ST_RESP;
            end
            ST_RESP: begin
                if (rspReady) state_next_s = ST_IDLE;
                else          state_next_s = ST_RESP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // ALU drive: selected byte pair during a step, all zero otherwise.
    always_comb begin
        aluA            = 8'h00;
        aluB            = 8'h00;
        aluCarryIn      = 1'b0;
        aluHalfCarry    = 1'b0;
        aluOpcode       = 4'h0;
        aluOutputEnable = 1'b0;
        if (step_s) begin
            aluA            = hi_sel_s ? work_a_r[15:8] : work_a_r[7:0];
            aluB            = hi_sel_s ? work_b_r[15:8] : work_b_r[7:0];
            aluCarryIn      = carry_r;
            aluHalfCarry    = half_r;
            aluOpcode       = op_r;
            aluOutputEnable = 1'b1;
        end else begin
            aluOutputEnable = 1'b0;
        end
    end

    // Response view of the work registers, exposed only while holding a result.
    always_comb begin
        rspResult = 16'h0000;
        rspC      = 1'b0;
        rspV      = 1'b0;
        rspH      = 1'b0;
        rspZ      = 1'b0;
        rspN      = 1'b0;
        if (state_r == ST_RESP) begin
            rspResult = wide_r ? work_a_r : {8'h00, work_a_r[7:0]};
            rspC      = carry_r;
            rspV      = vflag_r;
            rspH      = hflag_r;
            rspZ      = wide_r ? (work_a_r == 16'h0000) : (work_a_r[7:0] == 8'h00);
            rspN      = wide_r ? work_a_r[15] : work_a_r[7];
        end else begin
            rspResult = 16'h0000;
        end
    end

    // State and work registers: latch on accept, update one byte per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            work_a_r    <= 16'h0000;
            work_b_r    <= 16'h0000;
            carry_r     <= 1'b0;
            half_r      <= 1'b0;
            op_r        <= 4'h0;
            wide_r      <= 1'b0;
            remaining_r <= 3'd0;
            vflag_r     <= 1'b0;
            hflag_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && reqValid) begin
                work_a_r    <= reqA;
                work_b_r    <= reqB;
                carry_r     <= reqCarry;
                half_r      <= reqHalf;
                op_r        <= reqOp;
                wide_r      <= reqWide && wide_honoured(reqOp);
                remaining_r <= is_rotate(reqOp) ? reqCount : 3'd0;
                vflag_r     <= 1'b0;
                hflag_r     <= 1'b0;
            end else if (step_s) begin
                if (hi_sel_s) work_a_r[15:8] <= aluResult;
                else          work_a_r[7:0]  <= aluResult;
                carry_r <= aluC;
                vflag_r <= aluV;
                // Half carry is only meaningful out of the low nibble.
                if (!hi_sel_s) hflag_r <= aluH;
                if (iter_end_s && (remaining_r != 3'd0)) remaining_r <= remaining_r - 3'd1;
            end
        end
    end

endmodule
